// File: rtl/if_stage_ibuf.sv
// Fetch stage with a split-transaction instruction port, up to MAX_OUTSTANDING requests
// in flight and an IB_DEPTH-entry instruction buffer; optional FETCH_ADEF_EN address-error path.
module if_stage_ibuf #(
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
    parameter int          IB_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [63:0] if_to_id_bus,
    output logic        if_adef,
    input  logic [32:0] id_to_if_bus,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);
    localparam int AW = $clog2(IB_DEPTH);
    localparam int CW = AW + 1;

    logic        br_taken;
    logic [31:0] br_target;
    assign {br_taken, br_target} = id_to_if_bus;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [2:0]    out_cnt_q, out_cnt_d;
    logic [2:0]    disc_cnt_q, disc_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] ib_cnt_q, ib_cnt_d;
    logic [63:0]   ib_data_q [IB_DEPTH];

    logic        ib_empty, ib_has_space;
    logic        fetch_ok, adef_push;
    logic        accept, resp, keep_resp, push, pop;
    logic [63:0] push_data;
    logic [31:0] credit_used;

    assign ib_empty     = (ib_cnt_q == '0);
    assign ib_has_space = (ib_cnt_q < CW'(IB_DEPTH));
    // Entries already buffered plus live (non-discarded) responses still owed by memory.
    assign credit_used  = 32'(ib_cnt_q) + 32'(out_cnt_q) - 32'(disc_cnt_q);

`ifdef FETCH_ADEF_EN
    logic halt_q, halt_d;
    logic ib_adef_q [IB_DEPTH];

    assign fetch_ok  = (fetch_pc_q[1:0] == 2'b00);
    // A misaligned pc becomes a single flagged entry once all older traffic has drained.
    assign adef_push = ~fetch_ok & ~halt_q & ~br_taken & (out_cnt_q == 3'd0)
                     & (disc_cnt_q == 3'd0) & ib_has_space;
    assign if_adef   = ~ib_empty & ib_adef_q[rd_ptr_q];

    always_comb begin
        halt_d = halt_q;
        if (adef_push) halt_d = 1'b1;
        if (br_taken)  halt_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end

    always_ff @(posedge clk) begin
        if (push && !br_taken) ib_adef_q[wr_ptr_q] <= adef_push;
    end
`else
    assign fetch_ok  = 1'b1;
    assign adef_push = 1'b0;
    assign if_adef   = 1'b0;
`endif

    assign inst_req   = ~reset & ~br_taken & fetch_ok
                      & (out_cnt_q < 3'(MAX_OUTSTANDING))
                      & (credit_used < 32'(IB_DEPTH));
    assign inst_addr  = fetch_pc_q;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    assign accept    = inst_req & inst_addr_ok;
    // A data_ok with nothing outstanding is a protocol error and is ignored.
    assign resp      = inst_data_ok & (out_cnt_q != 3'd0);
    assign keep_resp = resp & (disc_cnt_q == 3'd0);
    assign push      = keep_resp | adef_push;
    assign push_data = keep_resp ? {resp_pc_q, inst_rdata} : {fetch_pc_q, 32'h0};

    assign if_to_id_valid = ~ib_empty & ~br_taken;
    assign if_to_id_bus   = ib_empty ? 64'h0 : ib_data_q[rd_ptr_q];
    assign pop            = if_to_id_valid & id_allowin;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_cnt_d  = out_cnt_q;
        disc_cnt_d = disc_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ib_cnt_d   = ib_cnt_q;

        case ({accept, resp})
            2'b10:   out_cnt_d = out_cnt_q + 3'd1;
            2'b01:   out_cnt_d = out_cnt_q - 3'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (accept)                      fetch_pc_d = fetch_pc_q + 32'd4;
        if (resp && disc_cnt_q != 3'd0)  disc_cnt_d = disc_cnt_q - 3'd1;
        if (keep_resp)                   resp_pc_d  = resp_pc_q + 32'd4;
        if (push)                        wr_ptr_d   = wr_ptr_q + AW'(1);
        if (pop)                         rd_ptr_d   = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   ib_cnt_d = ib_cnt_q + CW'(1);
            2'b01:   ib_cnt_d = ib_cnt_q - CW'(1);
            default: ib_cnt_d = ib_cnt_q;
        endcase

        // Redirect wins over everything: flush, retarget, and mark in-flight replies as stale.
        if (br_taken) begin
            fetch_pc_d = br_target;
            resp_pc_d  = br_target;
            disc_cnt_d = out_cnt_q - 3'(resp);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            ib_cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= 3'd0;
            disc_cnt_q <= 3'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            ib_cnt_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ib_cnt_q   <= ib_cnt_d;
        end
    end

    // NOTE: buffer storage has no reset; ib_cnt_q gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push && !br_taken) ib_data_q[wr_ptr_q] <= push_data;
    end

endmodule
